// File: rtl/bullet_pool_ctrl_if.sv
// Fire request / grant bundle between the shooters and the bullet pool.
// master = requester side, slave = pool controller.
interface bullet_pool_ctrl_if;
  logic       player_fire;
  logic [4:0] ship_x;
  logic       alien_fire;
  logic [4:0] alien_x;
  logic [3:0] alien_y;
  logic       player_grant;
  logic       alien_grant;

  modport master (
    output player_fire, ship_x,
    output alien_fire, alien_x, alien_y,
    input  player_grant, alien_grant
  );

  modport slave (
    input  player_fire, ship_x,
    input  alien_fire, alien_x, alien_y,
    output player_grant, alien_grant
  );
endinterface

// File: rtl/bullet_pool_ctrl.sv
// Shared bullet slot pool: arbitration, allocation,
// movement on a common tick and retirement on hit or edge.
module bullet_pool_ctrl #(
  parameter int NUM_SLOTS      = 4,
  parameter int TICK_CYCLES    = 90000,
  parameter int COOLDOWN_TICKS = 3,
  parameter int PLAYER_Y       = 12,
  parameter int ALIEN_Y_MAX    = 14
) (
  input  logic                   clk_36MHz,
  input  logic                   reset,
  input  logic                   enable,
  bullet_pool_ctrl_if.slave      fire,
  input  logic [NUM_SLOTS-1:0]   hit,
  output logic [NUM_SLOTS-1:0]   slot_active,
  output logic [NUM_SLOTS-1:0]   slot_dir,
  output logic [5*NUM_SLOTS-1:0] slot_x,
  output logic [4*NUM_SLOTS-1:0] slot_y,
  output logic                   player_busy,
  output logic                   tick
);
  localparam int CW = (TICK_CYCLES > 1) ?
                      $clog2(TICK_CYCLES) : 1;
  localparam int KW = (COOLDOWN_TICKS > 0) ?
                      $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam int IW = $clog2(NUM_SLOTS);

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [KW-1:0] COOL_LD  = KW'(COOLDOWN_TICKS);
  localparam logic [3:0]    P_Y      = 4'(PLAYER_Y);
  localparam logic [3:0]    A_Y_MAX  = 4'(ALIEN_Y_MAX);

  logic [CW-1:0]        cnt;
  logic [KW-1:0]        cool;
  logic                 prio_alien;
  logic [IW-1:0]        first_free;
  logic [IW-1:0]        second_free;
  logic [IW-1:0]        a_slot;
  logic                 any_free;
  logic                 two_free;
  logic                 p_elig;
  logic                 a_elig;
  logic                 p_win;
  logic                 a_win;
  logic [NUM_SLOTS-1:0] retire;
  logic [NUM_SLOTS-1:0] move;

  assign tick        = enable && (cnt == CNT_LAST);
  assign player_busy = |(slot_active & slot_dir);

  always_comb begin
    first_free  = '0;
    second_free = '0;
    any_free    = 1'b0;
    two_free    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_active[i]) begin
        if (!any_free) begin
          first_free = IW'(i);
          any_free   = 1'b1;
        end else if (!two_free) begin
          second_free = IW'(i);
          two_free    = 1'b1;
        end
      end
    end
  end

  assign p_elig = enable && fire.player_fire &&
                  !player_busy && (cool == '0) && any_free;
  assign a_elig = enable && fire.alien_fire &&
                  (fire.alien_y < A_Y_MAX) && any_free;

  // With a single free slot the priority holder wins.
  assign p_win  = p_elig && (!a_elig || two_free || !prio_alien);
  assign a_win  = a_elig && (!p_elig || two_free || prio_alien);
  assign a_slot = p_win ? second_free : first_free;

  always_comb begin
    retire = '0;
    move   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      retire[i] = slot_active[i] && (hit[i] || (tick &&
                  (slot_dir[i] ? (slot_y[4*i +: 4] == 4'd0)
                               : (slot_y[4*i +: 4] == A_Y_MAX))));
      move[i]   = slot_active[i] && tick && !retire[i];
    end
  end

  always_ff @(posedge clk_36MHz) begin
    if (!reset) begin
      cnt               <= '0;
      cool              <= '0;
      prio_alien        <= 1'b0;
      fire.player_grant <= 1'b0;
      fire.alien_grant  <= 1'b0;
      slot_active       <= '0;
      slot_dir          <= '0;
      slot_x            <= '0;
      slot_y            <= '0;
    end else begin
      if (enable) cnt <= tick ? '0 : cnt + CW'(1);
      fire.player_grant <= p_win;
      fire.alien_grant  <= a_win;
      if (p_win) cool <= COOL_LD;
      else if (tick && cool != '0) cool <= cool - KW'(1);
      if (p_elig && a_elig && !two_free) prio_alien <= !prio_alien;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (retire[i]) begin
          slot_active[i]     <= 1'b0;
          slot_dir[i]        <= 1'b0;
          slot_x[5*i +: 5]   <= '0;
          slot_y[4*i +: 4]   <= '0;
        end else if (move[i]) begin
          slot_y[4*i +: 4] <= slot_dir[i] ?
                              slot_y[4*i +: 4] - 4'd1 :
                              slot_y[4*i +: 4] + 4'd1;
        end else if (p_win && first_free == IW'(i)) begin
          slot_active[i]     <= 1'b1;
          slot_dir[i]        <= 1'b1;
          slot_x[5*i +: 5]   <= fire.ship_x;
          slot_y[4*i +: 4]   <= P_Y;
        end else if (a_win && a_slot == IW'(i)) begin
          slot_active[i]     <= 1'b1;
          slot_dir[i]        <= 1'b0;
          slot_x[5*i +: 5]   <= fire.alien_x;
          slot_y[4*i +: 4]   <= fire.alien_y + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Scoreboard bench for bullet_pool_ctrl: expected spawns are
// queued when a request is driven and matched against grants.
module tb_bullet_pool_ctrl;
  localparam int NS = 4;

  logic          clk_36MHz = 1'b0;
  logic          reset;
  logic          enable;
  logic [NS-1:0] hit;
  logic [NS-1:0] slot_active;
  logic [NS-1:0] slot_dir;
  logic [5*NS-1:0] slot_x;
  logic [4*NS-1:0] slot_y;
  logic          player_busy;
  logic          tick;

  bullet_pool_ctrl_if bus();

  bullet_pool_ctrl #(
    .NUM_SLOTS(NS), .TICK_CYCLES(8), .COOLDOWN_TICKS(3),
    .PLAYER_Y(12), .ALIEN_Y_MAX(14)
  ) dut (
    .clk_36MHz(clk_36MHz), .reset(reset), .enable(enable),
    .fire(bus.slave), .hit(hit),
    .slot_active(slot_active), .slot_dir(slot_dir),
    .slot_x(slot_x), .slot_y(slot_y),
    .player_busy(player_busy), .tick(tick)
  );

  always #14 clk_36MHz = ~clk_36MHz;

  typedef struct {
    int idx;
    int x;
    int y;
    int dir;
  } exp_t;

  exp_t pq[$];
  exp_t aq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(string tag, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sx(int i);
    return int'(slot_x[5*i +: 5]);
  endfunction

  function automatic int sy(int i);
    return int'(slot_y[4*i +: 4]);
  endfunction

  task automatic push_p(int idx, int x, int y, int dir);
    exp_t e;
    e.idx = idx; e.x = x; e.y = y; e.dir = dir;
    pq.push_back(e);
  endtask

  task automatic push_a(int idx, int x, int y, int dir);
    exp_t e;
    e.idx = idx; e.x = x; e.y = y; e.dir = dir;
    aq.push_back(e);
  endtask

  task automatic chk_slot(string who, exp_t e);
    chk({who, "_active"}, int'(slot_active[e.idx]), 1);
    chk({who, "_x"}, sx(e.idx), e.x);
    chk({who, "_y"}, sy(e.idx), e.y);
    chk({who, "_dir"}, int'(slot_dir[e.idx]), e.dir);
  endtask

  always @(negedge clk_36MHz) begin
    exp_t e;
    if (bus.player_grant) begin
      if (pq.size() == 0) chk("p_unexpected_grant", 1, 0);
      else begin
        e = pq.pop_front();
        chk_slot("p_spawn", e);
      end
    end
    if (bus.alien_grant) begin
      if (aq.size() == 0) chk("a_unexpected_grant", 1, 0);
      else begin
        e = aq.pop_front();
        chk_slot("a_spawn", e);
      end
    end
  end

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk_36MHz);
      n++;
    end while (!tick && n < 64);
    if (!tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic wait_empty(string tag);
    int n = 0;
    while ((pq.size() != 0 || aq.size() != 0) && n < 20) begin
      @(negedge clk_36MHz);
      n++;
    end
    chk(tag, pq.size() + aq.size(), 0);
  endtask

  task automatic fire_both(int px, int ax, int ay);
    bus.ship_x = 5'(px);
    bus.alien_x = 5'(ax);
    bus.alien_y = 4'(ay);
    bus.player_fire = 1'b1;
    bus.alien_fire = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ticks;
    reset = 1'b0; enable = 1'b1; hit = '0;
    bus.player_fire = 1'b0; bus.ship_x = '0;
    bus.alien_fire = 1'b0; bus.alien_x = '0; bus.alien_y = '0;
    repeat (3) @(negedge clk_36MHz);
    chk("rst_active", int'(slot_active), 0);
    chk("rst_x", int'(slot_x), 0);
    chk("rst_y", int'(slot_y), 0);
    chk("rst_dir", int'(slot_dir), 0);
    chk("rst_busy", int'(player_busy), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_pgrant", int'(bus.player_grant), 0);
    chk("rst_agrant", int'(bus.alien_grant), 0);
    reset = 1'b1;

    n = 0;
    while (!tick && n < 64) begin
      @(negedge clk_36MHz);
      n++;
    end
    chk("tick_first", n, 7);
    n = 0;
    do begin
      @(negedge clk_36MHz);
      n++;
    end while (!tick && n < 64);
    chk("tick_period", n, 8);

    // player shot granted on a tick edge, further fire ignored
    bus.ship_x = 5'd7;
    bus.player_fire = 1'b1;
    push_p(0, 7, 12, 1);
    repeat (4) @(negedge clk_36MHz);
    chk("p_busy", int'(player_busy), 1);
    bus.player_fire = 1'b0;
    wait_empty("p_first_grant");

    for (int k = 1; k <= 13; k++) begin
      wait_tick();
      @(negedge clk_36MHz);
      if (k < 13) chk("p_fly_y", sy(0), 12 - k);
      else chk("p_top_retire", int'(slot_active[0]), 0);
    end
    chk("p_busy_clear", int'(player_busy), 0);

    // cooldown: grant coincides with a tick, bullet hit at once
    wait_tick();
    bus.ship_x = 5'd9;
    bus.player_fire = 1'b1;
    push_p(0, 9, 12, 1);
    @(negedge clk_36MHz);
    hit = 4'b0001;
    @(negedge clk_36MHz);
    hit = '0;
    chk("cool_hit_retire", int'(slot_active[0]), 0);
    wait_tick();
    wait_tick();
    wait_tick();
    push_p(0, 9, 12, 1);
    wait_empty("cool_regrant");
    bus.player_fire = 1'b0;
    hit = 4'b0001;
    @(negedge clk_36MHz);
    hit = '0;
    repeat (4) wait_tick();

    // alien flight down to the last row
    wait_tick();
    bus.alien_x = 5'd20;
    bus.alien_y = 4'd3;
    bus.alien_fire = 1'b1;
    push_a(0, 20, 4, 0);
    @(negedge clk_36MHz);
    bus.alien_fire = 1'b0;
    wait_empty("a_grant");
    for (int k = 1; k <= 11; k++) begin
      wait_tick();
      @(negedge clk_36MHz);
      if (k < 11) chk("a_fly_y", sy(0), 4 + k);
      else chk("a_bottom_retire", int'(slot_active[0]), 0);
    end

    bus.alien_y = 4'd14;
    bus.alien_fire = 1'b1;
    repeat (20) @(negedge clk_36MHz);
    bus.alien_fire = 1'b0;
    chk("a_ymax_denied", int'(slot_active), 0);

    wait_tick();
    bus.alien_x = 5'd2;
    bus.alien_y = 4'd13;
    bus.alien_fire = 1'b1;
    push_a(0, 2, 14, 0);
    @(negedge clk_36MHz);
    bus.alien_fire = 1'b0;
    wait_empty("a_y13_grant");
    wait_tick();
    @(negedge clk_36MHz);
    chk("a_y13_retire", int'(slot_active[0]), 0);

    // fill slots 0..2 with alien bullets
    bus.alien_x = 5'd1;
    bus.alien_y = 4'd0;
    bus.alien_fire = 1'b1;
    push_a(0, 1, 1, 0);
    @(negedge clk_36MHz);
    push_a(1, 1, 1, 0);
    @(negedge clk_36MHz);
    push_a(2, 1, 1, 0);
    @(negedge clk_36MHz);
    bus.alien_fire = 1'b0;
    wait_empty("fill_three");

    fire_both(5, 9, 0);
    push_p(3, 5, 12, 1);
    repeat (3) @(negedge clk_36MHz);
    bus.player_fire = 1'b0;
    bus.alien_fire = 1'b0;
    wait_empty("one_free_player");
    chk("pool_full", int'(slot_active), 15);

    repeat (3) wait_tick();
    @(negedge clk_36MHz);
    hit = 4'b1000;
    @(negedge clk_36MHz);
    hit = '0;
    chk("hit3_retire", int'(slot_active[3]), 0);
    fire_both(4, 11, 5);
    push_a(3, 11, 6, 0);
    repeat (3) @(negedge clk_36MHz);
    bus.player_fire = 1'b0;
    bus.alien_fire = 1'b0;
    wait_empty("one_free_alien");

    hit = 4'b0001;
    @(negedge clk_36MHz);
    hit = '0;
    fire_both(2, 12, 5);
    push_p(0, 2, 12, 1);
    repeat (3) @(negedge clk_36MHz);
    bus.player_fire = 1'b0;
    bus.alien_fire = 1'b0;
    wait_empty("one_free_player2");

    // hit and tick in the same cycle, pool full
    wait_tick();
    hit = 4'b0010;
    bus.alien_x = 5'd8;
    bus.alien_y = 4'd0;
    bus.alien_fire = 1'b1;
    @(negedge clk_36MHz);
    chk("hit_tick_active", int'(slot_active[1]), 0);
    chk("hit_tick_y", sy(1), 0);
    hit = '0;
    push_a(1, 8, 1, 0);
    @(negedge clk_36MHz);
    bus.alien_fire = 1'b0;
    wait_empty("hit_realloc");

    // freeze with enable low
    reset = 1'b0;
    repeat (2) @(negedge clk_36MHz);
    chk("rst1_active", int'(slot_active), 0);
    chk("rst1_busy", int'(player_busy), 0);
    reset = 1'b1;
    bus.ship_x = 5'd3;
    bus.player_fire = 1'b1;
    push_p(0, 3, 12, 1);
    @(negedge clk_36MHz);
    bus.player_fire = 1'b0;
    enable = 1'b0;
    bus.alien_x = 5'd4;
    bus.alien_y = 4'd2;
    bus.alien_fire = 1'b1;
    ticks = 0;
    repeat (200) begin
      @(negedge clk_36MHz);
      if (tick) ticks++;
    end
    chk("freeze_ticks", ticks, 0);
    chk("freeze_y", sy(0), 12);
    chk("freeze_x", sx(0), 3);
    chk("freeze_one_slot", int'(slot_active), 1);
    hit = 4'b0001;
    @(negedge clk_36MHz);
    hit = '0;
    chk("freeze_hit", int'(slot_active[0]), 0);
    bus.alien_fire = 1'b0;
    @(negedge clk_36MHz);

    enable = 1'b1;
    bus.player_fire = 1'b1;
    bus.alien_fire = 1'b1;
    push_a(0, 4, 3, 0);
    @(negedge clk_36MHz);
    bus.alien_fire = 1'b0;
    repeat (4) @(negedge clk_36MHz);
    bus.player_fire = 1'b0;
    wait_empty("unfreeze_alien");

    // reset mid-flight clears slots and cooldown
    reset = 1'b0;
    @(negedge clk_36MHz);
    chk("rst2_active", int'(slot_active), 0);
    chk("rst2_y", int'(slot_y), 0);
    reset = 1'b1;
    bus.ship_x = 5'd6;
    bus.player_fire = 1'b1;
    push_p(0, 6, 12, 1);
    @(negedge clk_36MHz);
    bus.player_fire = 1'b0;
    wait_empty("rst_clears_cool");

    repeat (2) @(negedge clk_36MHz);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
